// File: rtl/k12a_pkg.sv
// Shared k12a definitions for the stack-pointer unit: bank index type,
// default interrupt bank and sticky fault-flag bit positions.
package k12a_pkg;

  localparam int K12A_NUM_SP   = 2;
  localparam int K12A_IRQ_BANK = 1;
  localparam int SP_BANK_W     = $clog2(K12A_NUM_SP);

  typedef logic [SP_BANK_W-1:0] sp_bank_t;

  localparam int FLT_OVF  = 0;
  localparam int FLT_UNF  = 1;
  localparam int FLT_NEST = 2;
  localparam int FLT_W    = 3;

  typedef logic [FLT_W-1:0] fault_vec_t;

endpackage

// File: rtl/k12a_sp_cell.sv
// One stack-pointer bank: register plus saturating inc/dec with bounds checks.
// The fault pulses are raised only while this bank is the active one.
module k12a_sp_cell #(
  parameter int                WIDTH       = 16,
  parameter int unsigned       STEP        = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]  STACK_FLOOR = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]  STACK_CEIL  = {WIDTH{1'b1}}
) (
  input  logic             cpu_clock,
  input  logic             reset_n,
  input  logic             active,
  input  logic             sp_store,
  input  logic             sp_inc,
  input  logic             sp_dec,
  input  logic [WIDTH-1:0] bus_value,
  output logic [WIDTH-1:0] sp_value,
  output logic             ovf_pulse,
  output logic             unf_pulse
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] sp_r;
  logic [WIDTH-1:0] sp_next_s;
  logic [WIDTH:0]   dec_s;
  logic [WIDTH:0]   inc_s;

  // Next pointer value; one extra bit catches borrow/carry so nothing wraps.
  always_comb begin
    dec_s     = {1'b0, sp_r} - STEP_X;
    inc_s     = {1'b0, sp_r} + STEP_X;
    sp_next_s = sp_r;
    ovf_pulse = 1'b0;
    unf_pulse = 1'b0;
    if (!active) begin
      sp_next_s = sp_r;
    end else if (sp_store) begin
      sp_next_s = bus_value;
    end else if (sp_inc && sp_dec) begin
      sp_next_s = sp_r;
    end else if (sp_dec) begin
      if (dec_s[WIDTH] || (dec_s < {1'b0, STACK_FLOOR})) begin
        ovf_pulse = 1'b1;
      end else begin
        sp_next_s = dec_s[WIDTH-1:0];
      end
    end else if (sp_inc) begin
      if (inc_s > {1'b0, STACK_CEIL}) begin
        unf_pulse = 1'b1;
      end else begin
        sp_next_s = inc_s[WIDTH-1:0];
      end
    end else begin
      sp_next_s = sp_r;
    end
  end

  // Bank register.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_r <= RESET_VALUE;
    end else begin
      sp_r <= sp_next_s;
    end
  end

  assign sp_value = sp_r;

endmodule

// File: rtl/k12a_sp_unit.sv
// Banked, bounds-checked stack pointer with interrupt bank switching,
// sticky fault flags and a tri-state drive onto the shared address bus.
module k12a_sp_unit
  import k12a_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               NUM_SP      = K12A_NUM_SP,
  parameter int               IRQ_BANK    = K12A_IRQ_BANK,
  parameter int unsigned      STEP        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] STACK_FLOOR = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] STACK_CEIL  = {WIDTH{1'b1}}
) (
  input  logic                      cpu_clock,
  input  logic                      reset_n,
  input  logic                      sp_load_n,
  input  logic                      sp_store,
  input  logic                      sp_inc,
  input  logic                      sp_dec,
  input  logic [$clog2(NUM_SP)-1:0] bank_sel,
  input  logic                      bank_we,
  input  logic                      irq_enter,
  input  logic                      irq_exit,
  input  logic                      fault_clear,
  inout  wire  [WIDTH-1:0]          addr_bus,
  output logic [WIDTH-1:0]          sp,
  output logic [$clog2(NUM_SP)-1:0] sp_bank,
  output logic                      in_irq,
  output logic                      sp_overflow,
  output logic                      sp_underflow,
  output logic                      irq_nest_fault
);

  localparam int             BW         = $clog2(NUM_SP);
  localparam logic [BW-1:0]  IRQ_BANK_X = BW'(IRQ_BANK);
  localparam logic [BW:0]    NUM_SP_X   = (BW+1)'(NUM_SP);

  logic [BW-1:0]    sp_bank_r;
  logic [BW-1:0]    saved_bank_r;
  logic             in_irq_r;
  fault_vec_t       fault_r;
  fault_vec_t       fault_next_s;
  logic             nest_s;
  logic [NUM_SP-1:0] ovf_s;
  logic [NUM_SP-1:0] unf_s;
  logic [WIDTH-1:0] bank_sp_s [NUM_SP];

  for (genvar g = 0; g < NUM_SP; g++) begin : g_bank
    k12a_sp_cell #(
      .WIDTH       (WIDTH),
      .STEP        (STEP),
      .RESET_VALUE (RESET_VALUE),
      .STACK_FLOOR (STACK_FLOOR),
      .STACK_CEIL  (STACK_CEIL)
    ) u_cell (
      .cpu_clock (cpu_clock),
      .reset_n   (reset_n),
      .active    (sp_bank_r == BW'(g)),
      .sp_store  (sp_store),
      .sp_inc    (sp_inc),
      .sp_dec    (sp_dec),
      .bus_value (addr_bus),
      .sp_value  (bank_sp_s[g]),
      .ovf_pulse (ovf_s[g]),
      .unf_pulse (unf_s[g])
    );
  end

  // Nesting fault detection and sticky-flag next state (new faults beat clear).
  always_comb begin
    nest_s = 1'b0;
    if (irq_enter && irq_exit) begin
      nest_s = 1'b1;
    end else if (irq_enter) begin
      nest_s = in_irq_r;
    end else if (irq_exit) begin
      nest_s = !in_irq_r;
    end else begin
      nest_s = 1'b0;
    end
    fault_next_s           = fault_clear ? {FLT_W{1'b0}} : fault_r;
    fault_next_s[FLT_OVF]  = fault_next_s[FLT_OVF]  | (|ovf_s);
    fault_next_s[FLT_UNF]  = fault_next_s[FLT_UNF]  | (|unf_s);
    fault_next_s[FLT_NEST] = fault_next_s[FLT_NEST] | nest_s;
  end

  // Bank pointer, interrupt save/restore and sticky flags.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_bank_r    <= {BW{1'b0}};
      saved_bank_r <= {BW{1'b0}};
      in_irq_r     <= 1'b0;
      fault_r      <= {FLT_W{1'b0}};
    end else begin
      fault_r <= fault_next_s;
      if (irq_enter && irq_exit) begin
        sp_bank_r <= sp_bank_r;
      end else if (irq_enter && !in_irq_r) begin
        saved_bank_r <= sp_bank_r;
        sp_bank_r    <= IRQ_BANK_X;
        in_irq_r     <= 1'b1;
      end else if (irq_exit && in_irq_r) begin
        sp_bank_r <= saved_bank_r;
        in_irq_r  <= 1'b0;
      end else if (!irq_enter && !irq_exit && bank_we && ({1'b0, bank_sel} < NUM_SP_X)) begin
        sp_bank_r <= bank_sel;
      end else begin
        sp_bank_r <= sp_bank_r;
      end
    end
  end

  assign sp             = bank_sp_s[sp_bank_r];
  assign addr_bus       = sp_load_n ? {WIDTH{1'bz}} : sp;
  assign sp_bank        = sp_bank_r;
  assign in_irq         = in_irq_r;
  assign sp_overflow    = fault_r[FLT_OVF];
  assign sp_underflow   = fault_r[FLT_UNF];
  assign irq_nest_fault = fault_r[FLT_NEST];

endmodule

// File: tb/tb_k12a_sp_unit.sv
// Scoreboard bench for k12a_sp_unit: directed scenarios plus random traffic
// checked against an integer-arithmetic model of the stack-pointer rules.
module tb_k12a_sp_unit;

  logic        cpu_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        sp_load_n = 1'b1;
  logic        sp_store  = 1'b0;
  logic        sp_inc    = 1'b0;
  logic        sp_dec    = 1'b0;
  logic [0:0]  bank_sel  = 1'b0;
  logic        bank_we   = 1'b0;
  logic        irq_enter = 1'b0;
  logic        irq_exit  = 1'b0;
  logic        fault_clear = 1'b0;
  logic        tb_bus_en = 1'b0;
  logic [15:0] tb_bus_val = 16'h0000;
  wire  [15:0] addr_bus;
  logic [15:0] sp;
  logic [0:0]  sp_bank;
  logic        in_irq, sp_overflow, sp_underflow, irq_nest_fault;

  assign addr_bus = tb_bus_en ? tb_bus_val : 16'hzzzz;

  k12a_sp_unit dut (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .sp_load_n(sp_load_n),
    .sp_store(sp_store), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .bank_sel(bank_sel), .bank_we(bank_we), .irq_enter(irq_enter),
    .irq_exit(irq_exit), .fault_clear(fault_clear), .addr_bus(addr_bus),
    .sp(sp), .sp_bank(sp_bank), .in_irq(in_irq), .sp_overflow(sp_overflow),
    .sp_underflow(sp_underflow), .irq_nest_fault(irq_nest_fault)
  );

  always #5 cpu_clock = ~cpu_clock;

  typedef struct {
    int sp; int bank; bit irq; bit ovf; bit unf; bit nest; bit ld_n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: plain integers, pointer range 0..65535.
  int m_bank[2];
  int m_act, m_saved;
  bit m_irq, m_ovf, m_unf, m_nest;

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_bank[0] = 0; m_bank[1] = 0;
    m_act = 0; m_saved = 0;
    m_irq = 0; m_ovf = 0; m_unf = 0; m_nest = 0;
  endfunction

  always @(posedge cpu_clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sp", int'(sp), e.sp);
      check("sp_bank", int'(sp_bank), e.bank);
      check("in_irq", int'(in_irq), int'(e.irq));
      check("sp_overflow", int'(sp_overflow), int'(e.ovf));
      check("sp_underflow", int'(sp_underflow), int'(e.unf));
      check("irq_nest_fault", int'(irq_nest_fault), int'(e.nest));
      if (!e.ld_n) check("addr_bus", int'(addr_bus), e.sp);
    end
  end

  task automatic step(bit ld_n, bit st, bit inc, bit dec, logic [15:0] bv,
                      bit bsel, bit bwe, bit ent, bit ext, bit fclr);
    int   cur;
    bit   new_ovf, new_unf, new_nest;
    exp_t e;
    @(negedge cpu_clock);
    sp_load_n = ld_n; sp_store = st; sp_inc = inc; sp_dec = dec;
    bank_sel = bsel; bank_we = bwe; irq_enter = ent; irq_exit = ext;
    fault_clear = fclr; tb_bus_val = bv; tb_bus_en = st & ld_n;
    cur = m_bank[m_act];
    new_ovf = 0; new_unf = 0; new_nest = 0;
    if (st) begin
      m_bank[m_act] = ld_n ? int'(bv) : cur;
    end else if (inc && dec) begin
      m_bank[m_act] = cur;
    end else if (dec) begin
      if (cur - 1 < 0) new_ovf = 1; else m_bank[m_act] = cur - 1;
    end else if (inc) begin
      if (cur + 1 > 65535) new_unf = 1; else m_bank[m_act] = cur + 1;
    end
    if (ent && ext) new_nest = 1;
    else if (ent) begin
      if (m_irq) new_nest = 1;
      else begin m_saved = m_act; m_act = 1; m_irq = 1; end
    end else if (ext) begin
      if (m_irq) begin m_act = m_saved; m_irq = 0; end
      else new_nest = 1;
    end else if (bwe && bsel < 2) m_act = int'(bsel);
    if (fclr) begin m_ovf = 0; m_unf = 0; m_nest = 0; end
    m_ovf |= new_ovf; m_unf |= new_unf; m_nest |= new_nest;
    e.sp = m_bank[m_act]; e.bank = m_act; e.irq = m_irq;
    e.ovf = m_ovf; e.unf = m_unf; e.nest = m_nest; e.ld_n = ld_n;
    q.push_back(e);
    @(posedge cpu_clock);
  endtask

  task automatic idle_inputs();
    sp_load_n = 1'b1; sp_store = 1'b0; sp_inc = 1'b0; sp_dec = 1'b0;
    bank_we = 1'b0; irq_enter = 1'b0; irq_exit = 1'b0; fault_clear = 1'b0;
    tb_bus_en = 1'b0;
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_sp"}, int'(sp), 0);
    check({tag, "_bank"}, int'(sp_bank), 0);
    check({tag, "_in_irq"}, int'(in_irq), 0);
    check({tag, "_flags"}, int'({sp_overflow, sp_underflow, irq_nest_fault}), 0);
  endtask

  initial begin
    logic [15:0] bv;
    model_reset();
    #3;
    check_reset_state("reset");
    @(negedge cpu_clock);
    reset_n = 1'b1;

    // ld_n st inc dec bus bsel bwe ent ext fclr
    step(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 16'h8000, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 16'h0001, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 16'h1234, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 16'h0000, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 16'h8000, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 16'h4000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 1);

    // Asynchronous reset between edges while a push is pending in an interrupt.
    @(negedge cpu_clock);
    idle_inputs();
    sp_dec = 1'b1; sp_load_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    check("async_reset_bus", int'(addr_bus), 0);
    model_reset();
    @(negedge cpu_clock);
    idle_inputs();
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 5)
        0: bv = 16'h0000;
        1: bv = 16'h0001;
        2: bv = 16'hFFFF;
        3: bv = 16'hFFFE;
        default: bv = 16'($urandom);
      endcase
      step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
           ($urandom % 3) == 0, bv, ($urandom % 2) == 1, ($urandom % 5) == 0,
           ($urandom % 10) == 0, ($urandom % 10) == 0, ($urandom % 8) == 0);
    end

    @(negedge cpu_clock);
    idle_inputs();
    @(posedge cpu_clock);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
